mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 18 +
 rtl/mem_arbiter.sv | 102 ++++++++++
 tb/tb_mem_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the two-port memory arbiter.
package mem_arb_pkg;

  localparam int DEFAULT_ADDR_W = 10;
  localparam int DEFAULT_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    RD_I,
    RD_D
  } state_e;

  typedef enum logic {
    PORT_I,
    PORT_D
  } port_e;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates a fetch port and a data port onto one single-port synchronous RAM.
// Define ARB_RR_EN for round-robin on contention; default is fixed data priority.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W,
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic              d_lock,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_e state_q;
  logic   lock_q;
  logic   contention;
  logic   d_wins;

  assign contention = i_req && d_req && !lock_q;

`ifdef ARB_RR_EN
  port_e last_win_q;

  // Last winner was fetch, so data takes this contention round.
  assign d_wins = (last_win_q == PORT_I);

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      last_win_q <= PORT_D;
    end else if (contention) begin
      last_win_q <= d_wins ? PORT_D : PORT_I;
    end
  end
`else
  assign d_wins = 1'b1;
`endif

  // Grants are gated by RSTn so reset silences the RAM interface at once.
  always_comb begin
    // NOTE: defaults first so every path assigns both grants and no latch is inferred.
    i_gnt = 1'b0;
    d_gnt = 1'b0;
    if (RSTn) begin
      if (lock_q) begin
        d_gnt = d_req;
      end else if (contention) begin
        d_gnt = d_wins;
        i_gnt = !d_wins;
      end else begin
        i_gnt = i_req;
        d_gnt = d_req;
      end
    end
  end

  assign mem_en    = i_gnt || d_gnt;
  assign mem_we    = d_gnt && d_we;
  assign mem_addr  = d_gnt ? d_addr : (i_gnt ? i_addr : '0);
  assign mem_wdata = mem_we ? d_wdata : '0;

  assign i_rvalid = (state_q == RD_I);
  assign d_rvalid = (state_q == RD_D);
  assign i_rdata  = mem_rdata;
  assign d_rdata  = mem_rdata;

  always_ff @(posedge CLK or negedge RSTn) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (!RSTn) begin
      state_q <= IDLE;
      lock_q  <= 1'b0;
    end else begin
      if (i_gnt) begin
        state_q <= RD_I;
      end else if (d_gnt && !d_we) begin
        state_q <= RD_D;
      end else begin
        state_q <= IDLE;
      end
      if (d_gnt) begin
        lock_q <= d_lock;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scenario bench for mem_arbiter with a behavioural RAM and a read-data scoreboard.
module tb_mem_arbiter;

  localparam int AW = 10;
  localparam int DW = 32;

  logic          CLK = 1'b0;
  logic          RSTn;
  logic          i_req, d_req, d_we, d_lock;
  logic [AW-1:0] i_addr, d_addr;
  logic [DW-1:0] d_wdata;
  logic          i_gnt, i_rvalid, d_gnt, d_rvalid;
  logic [DW-1:0] i_rdata, d_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  int checks = 0;
  int passes = 0;

  typedef struct {
    logic          is_d;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] exp_wr[int];

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .CLK(CLK), .RSTn(RSTn),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_lock(d_lock), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 CLK = ~CLK;

  function automatic logic [DW-1:0] init_word(input int a);
    init_word = 32'hC0DE_0000 ^ DW'(a);
  endfunction

  function automatic logic [DW-1:0] model_rd(input int a);
    if (exp_wr.exists(a)) model_rd = exp_wr[a];
    else model_rd = init_word(a);
  endfunction

  // Behavioural single-port RAM, one-cycle read latency.
  logic [DW-1:0] ram [0:(1<<AW)-1];
  bit            ram_init = 1'b0;
  always @(posedge CLK) begin
    if (!ram_init) begin
      for (int k = 0; k < (1 << AW); k++) ram[k] = init_word(k);
      ram_init = 1'b1;
      mem_rdata = '0;
    end else if (mem_en) begin
      if (mem_we) ram[mem_addr] = mem_wdata;
      else mem_rdata = ram[mem_addr];
    end
  end

  // Scoreboard: check last cycle's expected read, then record this cycle's grant.
  always @(negedge CLK) begin
    if (RSTn === 1'b1) begin
      exp_t e;
      checks++;
      if (i_gnt && d_gnt) $display("FAIL gnt_exclusive: i_gnt=%b d_gnt=%b required not both 1", i_gnt, d_gnt);
      else passes++;
      checks++;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        if (e.is_d) begin
          if (d_rvalid !== 1'b1 || i_rvalid !== 1'b0 || d_rdata !== e.data)
            $display("FAIL sb_d_read: rv_i=%b rv_d=%b data=%h required rv_d=1 data=%h", i_rvalid, d_rvalid, d_rdata, e.data);
          else passes++;
        end else begin
          if (i_rvalid !== 1'b1 || d_rvalid !== 1'b0 || i_rdata !== e.data)
            $display("FAIL sb_i_read: rv_i=%b rv_d=%b data=%h required rv_i=1 data=%h", i_rvalid, d_rvalid, i_rdata, e.data);
          else passes++;
        end
      end else begin
        if (i_rvalid !== 1'b0 || d_rvalid !== 1'b0)
          $display("FAIL sb_no_read: rv_i=%b rv_d=%b required 0 0", i_rvalid, d_rvalid);
        else passes++;
      end
      if (i_gnt) sb.push_back('{is_d: 1'b0, data: model_rd(int'(i_addr))});
      else if (d_gnt && !d_we) sb.push_back('{is_d: 1'b1, data: model_rd(int'(d_addr))});
      else if (d_gnt && d_we) exp_wr[int'(d_addr)] = d_wdata;
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n);
    i_req = 1'b0; d_req = 1'b0; d_we = 1'b0; d_lock = 1'b0;
    repeat (n) step();
  endtask

  task automatic test_reset();
    RSTn = 1'b0;
    i_req = 1'b1; d_req = 1'b1; d_we = 1'b1; d_lock = 1'b0;
    i_addr = 10'h004; d_addr = 10'h100; d_wdata = 32'h1;
    #2;
    checks++;
    if ({i_gnt, d_gnt, mem_en, mem_we, i_rvalid, d_rvalid} !== 6'b0)
      $display("FAIL reset_outputs: gnt/en/we/rv=%b required 000000", {i_gnt, d_gnt, mem_en, mem_we, i_rvalid, d_rvalid});
    else passes++;
    step();
    checks++;
    if ({i_gnt, d_gnt, mem_en, mem_we, i_rvalid, d_rvalid} !== 6'b0)
      $display("FAIL reset_after_edge: gnt/en/we/rv=%b required 000000", {i_gnt, d_gnt, mem_en, mem_we, i_rvalid, d_rvalid});
    else passes++;
    i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    step();
    RSTn = 1'b1;
    step();
  endtask

  task automatic test_fetch_solo();
    i_req = 1'b1; i_addr = 10'h004;
    #2;
    checks++;
    if ({i_gnt, d_gnt, mem_en, mem_we} !== 4'b1010 || mem_addr !== 10'h004)
      $display("FAIL fetch_grant: gnt/en/we=%b addr=%h required 1010 addr=004", {i_gnt, d_gnt, mem_en, mem_we}, mem_addr);
    else passes++;
    step();
    i_req = 1'b0;
    #2;
    checks++;
    if (i_rvalid !== 1'b1 || i_rdata !== init_word(4))
      $display("FAIL fetch_rdata: rv=%b data=%h required 1 %h", i_rvalid, i_rdata, init_word(4));
    else passes++;
    idle(2);
  endtask

`ifdef ARB_RR_EN
  task automatic test_round_robin();
    logic [1:0] exp_g [4];
    exp_g[0] = 2'b10; exp_g[1] = 2'b01; exp_g[2] = 2'b10; exp_g[3] = 2'b01;
    RSTn = 1'b0;
    sb.delete();
    step();
    RSTn = 1'b1;
    step();
    i_req = 1'b1; i_addr = 10'h008;
    d_req = 1'b1; d_we = 1'b0; d_addr = 10'h100;
    for (int c = 0; c < 4; c++) begin
      #2;
      checks++;
      if ({i_gnt, d_gnt} !== exp_g[c])
        $display("FAIL rr_cycle%0d: i_gnt,d_gnt=%b required %b", c, {i_gnt, d_gnt}, exp_g[c]);
      else passes++;
      step();
    end
    idle(2);
  endtask
`else
  task automatic test_fixed_priority();
    i_req = 1'b1; i_addr = 10'h008;
    d_req = 1'b1; d_we = 1'b0; d_addr = 10'h100;
    #2;
    checks++;
    if ({i_gnt, d_gnt} !== 2'b01 || mem_addr !== 10'h100)
      $display("FAIL prio_first: i_gnt,d_gnt=%b addr=%h required 01 addr=100", {i_gnt, d_gnt}, mem_addr);
    else passes++;
    step();
    d_req = 1'b0;
    #2;
    checks++;
    if ({i_gnt, d_gnt} !== 2'b10 || d_rvalid !== 1'b1)
      $display("FAIL prio_second: i_gnt,d_gnt=%b d_rvalid=%b required 10 and 1", {i_gnt, d_gnt}, d_rvalid);
    else passes++;
    step();
    i_req = 1'b0;
    #2;
    checks++;
    if (i_rvalid !== 1'b1 || d_rvalid !== 1'b0)
      $display("FAIL prio_rvalid_order: rv_i=%b rv_d=%b required 1 0", i_rvalid, d_rvalid);
    else passes++;
    idle(2);
  endtask
`endif

  task automatic test_write();
    d_req = 1'b1; d_we = 1'b1; d_addr = 10'h010; d_wdata = 32'hDEAD_BEEF;
    #2;
    checks++;
    if ({d_gnt, mem_en, mem_we} !== 3'b111 || mem_addr !== 10'h010 || mem_wdata !== 32'hDEAD_BEEF)
      $display("FAIL write_grant: gnt/en/we=%b addr=%h wdata=%h required 111 010 deadbeef", {d_gnt, mem_en, mem_we}, mem_addr, mem_wdata);
    else passes++;
    step();
    d_req = 1'b0; d_we = 1'b0;
    #2;
    checks++;
    if (mem_we !== 1'b0 || d_rvalid !== 1'b0)
      $display("FAIL write_no_rvalid: mem_we=%b d_rvalid=%b required 0 0", mem_we, d_rvalid);
    else passes++;
    step();
    d_req = 1'b1; d_addr = 10'h010;
    step();
    d_req = 1'b0;
    #2;
    checks++;
    if (d_rvalid !== 1'b1 || d_rdata !== 32'hDEAD_BEEF)
      $display("FAIL write_readback: rv=%b data=%h required 1 deadbeef", d_rvalid, d_rdata);
    else passes++;
    idle(2);
  endtask

  task automatic test_lock();
    d_req = 1'b1; d_we = 1'b0; d_lock = 1'b1; d_addr = 10'h020;
    #2;
    checks++;
    if ({i_gnt, d_gnt} !== 2'b01)
      $display("FAIL lock_take: i_gnt,d_gnt=%b required 01", {i_gnt, d_gnt});
    else passes++;
    step();
    d_req = 1'b0; d_lock = 1'b0; i_req = 1'b1; i_addr = 10'h024;
    #2;
    checks++;
    if ({i_gnt, d_gnt, mem_en} !== 3'b000)
      $display("FAIL lock_hold: i_gnt,d_gnt,mem_en=%b required 000", {i_gnt, d_gnt, mem_en});
    else passes++;
    step();
    d_req = 1'b1; d_we = 1'b1; d_lock = 1'b0; d_addr = 10'h030; d_wdata = 32'h1234_5678;
    #2;
    checks++;
    if ({i_gnt, d_gnt} !== 2'b01)
      $display("FAIL lock_release_gnt: i_gnt,d_gnt=%b required 01", {i_gnt, d_gnt});
    else passes++;
    step();
    d_req = 1'b0; d_we = 1'b0;
    #2;
    checks++;
    if ({i_gnt, d_gnt} !== 2'b10)
      $display("FAIL lock_fetch_resume: i_gnt,d_gnt=%b required 10", {i_gnt, d_gnt});
    else passes++;
    step();
    idle(2);
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp_g [3];
    exp_g[0] = 2'b10; exp_g[1] = 2'b01; exp_g[2] = 2'b10;
    for (int c = 0; c < 3; c++) begin
      i_req = exp_g[c][1]; d_req = exp_g[c][0]; d_we = 1'b0;
      i_addr = AW'(10'h040 + c); d_addr = AW'(10'h040 + c);
      #2;
      checks++;
      if ({i_gnt, d_gnt} !== exp_g[c] || mem_addr !== AW'(10'h040 + c))
        $display("FAIL b2b_cycle%0d: gnt=%b addr=%h required %b addr=%h", c, {i_gnt, d_gnt}, mem_addr, exp_g[c], AW'(10'h040 + c));
      else passes++;
      step();
    end
    idle(2);
  endtask

  task automatic test_reset_inflight();
    i_req = 1'b1; i_addr = 10'h050;
    #2;
    checks++;
    if (i_gnt !== 1'b1)
      $display("FAIL rst_inflight_grant: i_gnt=%b required 1", i_gnt);
    else passes++;
    step();
    RSTn = 1'b0;
    sb.delete();
    #2;
    checks++;
    if ({i_gnt, d_gnt, mem_en, mem_we, i_rvalid, d_rvalid} !== 6'b0 || mem_addr !== '0)
      $display("FAIL rst_inflight_outputs: gnt/en/we/rv=%b addr=%h required 000000 000", {i_gnt, d_gnt, mem_en, mem_we, i_rvalid, d_rvalid}, mem_addr);
    else passes++;
    step();
    i_req = 1'b0;
    step();
    RSTn = 1'b1;
    for (int c = 0; c < 2; c++) begin
      #2;
      checks++;
      if (i_rvalid !== 1'b0 || d_rvalid !== 1'b0)
        $display("FAIL rst_inflight_discard%0d: rv_i=%b rv_d=%b required 0 0", c, i_rvalid, d_rvalid);
      else passes++;
      step();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    RSTn = 1'b0;
    i_req = 1'b0; d_req = 1'b0; d_we = 1'b0; d_lock = 1'b0;
    i_addr = '0; d_addr = '0; d_wdata = '0;
    step();
    test_reset();
    test_fetch_solo();
`ifdef ARB_RR_EN
    test_round_robin();
`else
    test_fixed_priority();
`endif
    test_write();
    test_lock();
    test_back_to_back();
    test_reset_inflight();
    checks++;
    if (sb.size() != 0)
      $display("FAIL sb_drained: %0d entries left required 0", sb.size());
    else passes++;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
